// File: rtl/NVP_v1_constants.sv
// Shared NVP v1 sizing constants for the activation line buffer.
package NVP_v1_constants;
   localparam int ACTIVATION_BANK_BIT_WIDTH    = 8;
   localparam int ACTIVATION_BUFFER_BANK_COUNT = 4;
   localparam int ACTIVATION_LINE_BUFFER_DEPTH = 10;
endpackage

// File: rtl/activation_line_buffer_reader_pkg.sv
// Types shared by the activation line buffer reader, its stream interface and skid FIFO.
package activation_line_buffer_reader_pkg;
   import NVP_v1_constants::*;

   localparam int DW = ACTIVATION_BANK_BIT_WIDTH * ACTIVATION_BUFFER_BANK_COUNT;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN
   } rd_state_e;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } fifo_entry_t;
endpackage

// File: rtl/activation_line_buffer_reader_if.sv
// Line stream from the reader toward the stream reader (valid/ready with last marker).
interface activation_line_buffer_reader_if
   import activation_line_buffer_reader_pkg::*;
#(
   parameter int LINE_W = DW
) ();
   logic [LINE_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/activation_read_skid_fifo.sv
// Two-entry register FIFO; head always lives in entry 0 so outputs come straight from flops.
module activation_read_skid_fifo
   import activation_line_buffer_reader_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        push_i,
   input  fifo_entry_t push_entry_i,
   input  logic        pop_i,
   output logic [1:0]  count_o,
   output fifo_entry_t head_o
);
   fifo_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pop_ok, push_ok;

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      cnt_d   = cnt_q;
      pop_ok  = pop_i && (cnt_q != 2'd0);
      push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
      if (pop_ok) begin
         ent0_d = ent1_q;
         cnt_d  = cnt_q - 2'd1;
      end
      // Push lands behind whatever survives the pop.
      if (push_ok) begin
         if (cnt_d == 2'd0) ent0_d = push_entry_i;
         else               ent1_d = push_entry_i;
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign head_o  = ent0_q;
endmodule

// File: rtl/activation_line_buffer_reader.sv
// Compute-side read sequencer: walks an address range, absorbs 1-cycle read latency, streams lines.
// Optional stall counter output when NVP_ACTIVATION_READER_STALL_COUNT_EN is defined.
module activation_line_buffer_reader
   import activation_line_buffer_reader_pkg::*;
#(
   parameter int ACTIVATION_BANK_BIT_WIDTH    = NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH,
   parameter int ACTIVATION_BUFFER_BANK_COUNT = NVP_v1_constants::ACTIVATION_BUFFER_BANK_COUNT,
   parameter int ACTIVATION_LINE_BUFFER_DEPTH = NVP_v1_constants::ACTIVATION_LINE_BUFFER_DEPTH,
   localparam int AW   = $clog2(ACTIVATION_LINE_BUFFER_DEPTH),
   localparam int CW   = AW + 1,
   localparam int BDW  = ACTIVATION_BANK_BIT_WIDTH * ACTIVATION_BUFFER_BANK_COUNT
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           i_start,
   input  logic [AW-1:0]  i_base_address,
   input  logic [CW-1:0]  i_word_count,
   output logic           o_busy,
   output logic           o_done,
   output logic [AW-1:0]  o_activation_buffer_address_in_compute,
   input  logic [BDW-1:0] i_activation_buffer_data_out,
   activation_line_buffer_reader_if.master strm
`ifdef NVP_ACTIVATION_READER_STALL_COUNT_EN
   ,output logic [31:0]   o_stall_cycles
`endif
);
   localparam logic [AW-1:0] LAST_ADDR = AW'(ACTIVATION_LINE_BUFFER_DEPTH - 1);

   rd_state_e   state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] remain_q, remain_d;
   logic        inflight_q, inflight_d;
   logic        inflight_last_q, inflight_last_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  fifo_cnt;
   fifo_entry_t head, push_entry;
   logic        fifo_valid, pop, can_issue, accept;

   assign fifo_valid = (fifo_cnt != 2'd0);
   assign pop        = fifo_valid && strm.ready;
   assign accept     = (state_q == ST_IDLE) && i_start;
   // Issue only if the line can still find a FIFO slot once it returns.
   assign can_issue  = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      remain_d        = remain_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      busy_d          = busy_q;
      done_d          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (i_word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d   = i_base_address;
                  remain_d = i_word_count;
                  busy_d   = 1'b1;
                  state_d  = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (can_issue) begin
               inflight_d      = 1'b1;
               inflight_last_d = (remain_q == CW'(1));
               remain_d        = remain_q - CW'(1);
               addr_d          = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
               if (remain_q == CW'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign push_entry.data = i_activation_buffer_data_out;
   assign push_entry.last = inflight_last_q;

   activation_read_skid_fifo u_fifo (
      .clk          (clk),
      .resetn       (resetn),
      .push_i       (inflight_q),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .count_o      (fifo_cnt),
      .head_o       (head)
   );

`ifdef NVP_ACTIVATION_READER_STALL_COUNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk) begin
      if (!resetn)                                     stall_q <= '0;
      else if (accept)                                 stall_q <= '0;
      else if (fifo_valid && !strm.ready && stall_q != '1) stall_q <= stall_q + 32'd1;
   end
   assign o_stall_cycles = stall_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_activation_buffer_address_in_compute = addr_q;
   assign strm.data  = head.data;
   assign strm.valid = fifo_valid;
   assign strm.last  = head.last;
endmodule
